mux2_port_arbiter: RTL and testbench
====================================

// Module: mux2_port_arbiter
// PURPOSE
//  Round-robin arbiter sharing one synchronous-read memory port (weight/feature ROM) between two
//  requesters, e.g. conv engine (0) and FC engine (1). Grants one whole burst at a time.
//  Drives sel_o to the external Mux2 that steers the data path, and generates the burst addresses.
//  Sits between the layer engines and the BRAM in the CNN datapath.
// PARAMETERS
//  ADDR_W  10  memory address width
//  DATA_W   8  memory data width
//  LEN_W    8  burst length width, in words
// PORTS
//  clk       in   1       clock, rising edge
//  rst       in   1       synchronous, active-high reset
//  req_i     in   2       per-requester burst request, level; held until done_o[n]
//  base0_i   in   ADDR_W  requester 0 burst start address
//  base1_i   in   ADDR_W  requester 1 burst start address
//  len0_i    in   LEN_W   requester 0 burst length in words
//  len1_i    in   LEN_W   requester 1 burst length in words
//  mem_rd_o  out  1       memory read strobe
//  mem_addr_o out ADDR_W  memory read address
//  mem_rdata_i in DATA_W  memory read data, valid 1 cycle after mem_rd_o
//  sel_o     out  1       current owner; drives the Mux2 sel
//  gnt_o     out  2       one-hot grant, high for the whole burst incl. DONE
//  rdata_o   out  DATA_W  mem_rdata_i forwarded to both requesters
//  rvalid_o  out  2       per-requester read-data valid
//  done_o    out  2       one-cycle burst-complete pulse
// BEHAVIOUR
//  All outputs registered except rdata_o (= mem_rdata_i).
//  Reset: state=IDLE; mem_rd_o, gnt_o, rvalid_o, done_o = 0; mem_addr_o = 0; sel_o = 0;
//  last_q = 1, so requester 0 wins the first tie.
//  FSM: IDLE -> BURST -> DONE -> IDLE.
//  IDLE:
//   - Only one req_i bit set: grant it. Both set: grant ~last_q. None set: stay.
//   - On grant: latch base/len of the winner; set sel_o and gnt_o; last_q <= winner.
//   - len=0: go directly to DONE with no reads.
//  BURST:
//   - mem_rd_o=1, mem_addr_o = base + cnt, cnt 0..len-1, one read per cycle.
//   - Address add wraps modulo 2^ADDR_W.
//   - After the read with cnt=len-1, go to DONE.
//  DONE: mem_rd_o=0; done_o[owner]=1 for 1 cycle; gnt_o cleared on exit; next state IDLE.
//  rvalid_o[owner] = registered mem_rd_o: asserted the cycle after each read.
//  The last rvalid_o coincides with done_o.
//  Timing: request seen in IDLE at cycle T -> reads in T+1..T+len; done_o at T+len+1; IDLE at T+len+2.
//  Min gap between bursts is 1 IDLE cycle.
//  Requester must drop req_i on the edge at which it samples done_o; a req_i still high in IDLE is a new request.
//  req_i deasserted mid-burst is ignored; the burst completes and done_o still pulses.
//  base/len changes after grant are ignored; they are latched once per burst.
//  The non-owner's req_i stays pending, with no timeout; it is guaranteed the next grant.
//  sel_o holds the last owner while IDLE; it changes only on a grant.
//  rst mid-burst: return to reset values next cycle; the in-flight read's rvalid is suppressed; no done_o.
// TESTING
//  1 Single: req_i=01, base0=0x010, len0=4 -> addr 0x010..0x013 on cycles T+1..T+4;
//    rvalid_o=01 for T+2..T+5; done_o=01 at T+5.
//  2 Tie: req_i=11 from reset -> req0 served first, then req1 (after 1 IDLE cycle);
//    next tie goes to req0 again (alternation).
//  3 Starvation: req0 re-requests immediately while req1 is pending -> req1 granted next;
//    sel_o toggles 0->1.
//  4 len1=0 -> no mem_rd_o; done_o=10 the cycle after grant.
//  5 Wrap: base0=0x3FE, len0=4 -> addresses 0x3FE, 0x3FF, 0x000, 0x001.
//  6 rst asserted at read 2 of 4 -> next cycle all outputs 0, no rvalid/done;
//    a fresh req_i=01 restarts the burst from base0.

Source files
------------

// File: rtl/mux2_port_arbiter.sv
// -----------------------------------------------------------------------------
// mux2_port_arbiter
//
// Round-robin arbiter that shares one synchronous-read memory port (weight /
// feature ROM) between two requesters, typically the conv engine (0) and the
// FC engine (1). A grant covers one whole burst. The arbiter drives the select
// of the external Mux2 that steers the read data path and generates the burst
// read addresses itself.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   req_i[1:0]   per-requester burst request (level, held until done_o[n])
//   base0_i      requester 0 burst start address
//   base1_i      requester 1 burst start address
//   len0_i       requester 0 burst length in words (0 = empty burst)
//   len1_i       requester 1 burst length in words (0 = empty burst)
//   mem_rd_o     memory read strobe
//   mem_addr_o   memory read address
//   mem_rdata_i  memory read data, valid one cycle after mem_rd_o
//   sel_o        current / last owner, drives the Mux2 select
//   gnt_o[1:0]   one-hot grant, high from grant through the DONE cycle
//   rdata_o      mem_rdata_i forwarded to both requesters
//   rvalid_o     per-requester read-data valid
//   done_o       one-cycle burst-complete pulse, coincides with last rvalid
//
// Timing: a request seen in IDLE at edge T produces reads in cycles
// T+1..T+len, done_o in cycle T+len+1, and IDLE again in cycle T+len+2.
// All outputs are registered except rdata_o.
// -----------------------------------------------------------------------------
module mux2_port_arbiter #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_i,
  input  logic [ADDR_W-1:0] base0_i,
  input  logic [ADDR_W-1:0] base1_i,
  input  logic [LEN_W-1:0]  len0_i,
  input  logic [LEN_W-1:0]  len1_i,
  output logic              mem_rd_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              sel_o,
  output logic [1:0]        gnt_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rvalid_o,
  output logic [1:0]        done_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic                last_q,   last_d;
  logic                sel_q,    sel_d;
  logic [1:0]          gnt_q,    gnt_d;
  logic                mem_rd_q, mem_rd_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [ADDR_W-1:0]   base_q,   base_d;
  logic [LEN_W-1:0]    len_q,    len_d;
  logic [LEN_W-1:0]    cnt_q,    cnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [1:0]          done_q,   done_d;

  // Per-requester views of the burst descriptors, indexed by requester id.
  logic [ADDR_W-1:0]   cand_base [2];
  logic [LEN_W-1:0]    cand_len  [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_cand
    if (gi == 0) begin : g_r0
      assign cand_base[gi] = base0_i;
      assign cand_len[gi]  = len0_i;
    end else begin : g_r1
      assign cand_base[gi] = base1_i;
      assign cand_len[gi]  = len1_i;
    end
  end

  // Arbitration: a lone request wins outright; on a tie the requester that
  // did not own the previous burst wins, so a pending request is always
  // served next even if the other side re-requests immediately.
  logic                win_valid;
  logic                win_id;
  logic [1:0]          win_onehot;
  logic [ADDR_W-1:0]   win_base;
  logic [LEN_W-1:0]    win_len;

  always_comb begin
    win_valid  = |req_i;
    win_id     = (req_i == 2'b11) ? ~last_q : req_i[1];
    win_onehot = win_id ? 2'b10 : 2'b01;
    win_base   = cand_base[win_id];
    win_len    = cand_len[win_id];
  end

  // One-hot of the current owner; used for rvalid/done steering.
  logic [1:0]          owner_onehot;
  logic [LEN_W-1:0]    cnt_inc;
  logic                last_beat;

  always_comb begin
    owner_onehot = sel_q ? 2'b10 : 2'b01;
    cnt_inc      = cnt_q + 1'b1;
    // len_q is never zero in BURST, so len_q-1 cannot underflow there.
    last_beat    = (cnt_q == (len_q - 1'b1));
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    sel_d    = sel_q;
    gnt_d    = gnt_q;
    mem_rd_d = mem_rd_q;
    addr_d   = addr_q;
    base_d   = base_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    done_d   = 2'b00;
    // Read data returns one cycle after each strobe, so rvalid is the strobe
    // delayed by one edge and steered to the owner.
    rvalid_d = mem_rd_q ? owner_onehot : 2'b00;

    unique case (state_q)
      ST_IDLE: begin
        mem_rd_d = 1'b0;
        if (win_valid) begin
          sel_d  = win_id;
          last_d = win_id;
          gnt_d  = win_onehot;
          base_d = win_base;
          len_d  = win_len;
          cnt_d  = '0;
          if (win_len == '0) begin
            // Empty burst: skip straight to the completion pulse.
            state_d = ST_DONE;
            done_d  = win_onehot;
          end else begin
            state_d  = ST_BURST;
            mem_rd_d = 1'b1;
            addr_d   = win_base;
          end
        end
      end

      ST_BURST: begin
        if (last_beat) begin
          state_d  = ST_DONE;
          mem_rd_d = 1'b0;
          done_d   = owner_onehot;
        end else begin
          cnt_d  = cnt_inc;
          // Natural ADDR_W-bit overflow gives the modulo-2^ADDR_W wrap.
          addr_d = base_q + ADDR_W'(cnt_inc);
        end
      end

      ST_DONE: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        gnt_d    = 2'b00;
      end

      default: begin
        state_d  = ST_IDLE;
        mem_rd_d = 1'b0;
        gnt_d    = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      last_q   <= 1'b1;     // requester 0 wins the first tie
      sel_q    <= 1'b0;
      gnt_q    <= 2'b00;
      mem_rd_q <= 1'b0;
      addr_q   <= '0;
      base_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      rvalid_q <= 2'b00;    // also drops the rvalid of an in-flight read
      done_q   <= 2'b00;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      sel_q    <= sel_d;
      gnt_q    <= gnt_d;
      mem_rd_q <= mem_rd_d;
      addr_q   <= addr_d;
      base_q   <= base_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
    end
  end

  assign mem_rd_o   = mem_rd_q;
  assign mem_addr_o = addr_q;
  assign sel_o      = sel_q;
  assign gnt_o      = gnt_q;
  assign rvalid_o   = rvalid_q;
  assign done_o     = done_q;
  assign rdata_o    = mem_rdata_i;

endmodule

// File: tb/tb_mux2_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux2_port_arbiter
//
// Directed scenarios with hand-computed expectations, followed by randomized
// traffic. A transaction-level reference model (current burst: owner, base,
// len and cycles elapsed since grant) gives the expected value of every
// output on every cycle; the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mux2_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req_i = 2'b00;
  logic [ADDR_W-1:0] base0_i = '0;
  logic [ADDR_W-1:0] base1_i = '0;
  logic [LEN_W-1:0]  len0_i = '0;
  logic [LEN_W-1:0]  len1_i = '0;
  logic [DATA_W-1:0] mem_rdata_i = '0;
  logic              mem_rd_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              sel_o;
  logic [1:0]        gnt_o;
  logic [DATA_W-1:0] rdata_o;
  logic [1:0]        rvalid_o;
  logic [1:0]        done_o;

  mux2_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .base0_i    (base0_i),
    .base1_i    (base1_i),
    .len0_i     (len0_i),
    .len1_i     (len1_i),
    .mem_rd_o   (mem_rd_o),
    .mem_addr_o (mem_addr_o),
    .mem_rdata_i(mem_rdata_i),
    .sel_o      (sel_o),
    .gnt_o      (gnt_o),
    .rdata_o    (rdata_o),
    .rvalid_o   (rvalid_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // ROM contents as a function of address.
  function automatic logic [7:0] rom_f(input logic [ADDR_W-1:0] a);
    logic [7:0] v;
    v = (a[7:0] * 8'd13) ^ {6'd0, a[9:8]} ^ 8'h5A;
    return v;
  endfunction

  // Synchronous-read memory: data one cycle after the strobe.
  always @(posedge clk) begin
    if (mem_rd_o) mem_rdata_i <= rom_f(mem_addr_o);
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. A burst of length L granted at edge T occupies cycles
  // k = 1..L+1 after the grant: reads at k = 1..L (address base+k-1), read
  // data valid at k = 2..L+1, done at k = L+1; the arbiter is free again the
  // cycle after that.
  // ---------------------------------------------------------------------------
  int                m_busy = 0;
  int                m_owner = 0;
  int                m_len = 0;
  int                m_k = 0;
  int                m_last = 1;
  int                m_sel = 0;
  int                m_after_rst = 0;
  logic [ADDR_W-1:0] m_base = '0;

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        m_busy = 0; m_k = 0; m_last = 1; m_sel = 0; m_after_rst = 1;
      end else begin
        m_after_rst = 0;
        if (m_busy != 0) begin
          if (m_k == m_len + 1) m_busy = 0;
          else m_k++;
        end else if (req_i != 2'b00) begin
          if (req_i == 2'b11) m_owner = 1 - m_last;
          else m_owner = req_i[1] ? 1 : 0;
          m_base = (m_owner == 1) ? base1_i : base0_i;
          m_len  = (m_owner == 1) ? int'(len1_i) : int'(len0_i);
          m_k    = 1;
          m_busy = 1;
          m_last = m_owner;
          m_sel  = m_owner;
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial begin
    logic [1:0]        oh, e_gnt, e_rv, e_done;
    logic              e_rd;
    logic [ADDR_W-1:0] e_addr, e_daddr;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        oh     = (m_owner == 1) ? 2'b10 : 2'b01;
        e_gnt  = (m_busy != 0) ? oh : 2'b00;
        e_rd   = (m_busy != 0) && (m_k <= m_len);
        e_rv   = ((m_busy != 0) && m_k >= 2 && m_k <= m_len + 1) ? oh : 2'b00;
        e_done = ((m_busy != 0) && m_k == m_len + 1) ? oh : 2'b00;
        e_addr = m_base + ADDR_W'(m_k - 1);
        e_daddr = m_base + ADDR_W'(m_k - 2);
        chk("mdl_mem_rd", int'(mem_rd_o), int'(e_rd));
        chk("mdl_gnt",    int'(gnt_o),    int'(e_gnt));
        chk("mdl_sel",    int'(sel_o),    m_sel);
        chk("mdl_rvalid", int'(rvalid_o), int'(e_rv));
        chk("mdl_done",   int'(done_o),   int'(e_done));
        if (e_rd) chk("mdl_addr", int'(mem_addr_o), int'(e_addr));
        if (m_after_rst != 0) chk("mdl_addr_rst", int'(mem_addr_o), 0);
        if (e_rv != 2'b00) chk("mdl_rdata", int'(rdata_o), int'(rom_f(e_daddr)));
      end
    end
  end

  function automatic logic [LEN_W-1:0] pick_len();
    if ($urandom_range(0, 4) == 0) return LEN_W'($urandom_range(0, 40));
    return LEN_W'($urandom_range(0, 5));
  endfunction

  initial begin
    logic [ADDR_W-1:0] a;
    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_mem_rd", int'(mem_rd_o), 0);
    chk("rst_addr",   int'(mem_addr_o), 0);
    chk("rst_gnt",    int'(gnt_o), 0);
    chk("rst_sel",    int'(sel_o), 0);
    chk("rst_rvalid", int'(rvalid_o), 0);
    chk("rst_done",   int'(done_o), 0);
    rst = 1'b0;

    // 1: single burst, base 0x010, len 4
    req_i = 2'b01; base0_i = 10'h010; len0_i = 8'd4;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      chk("t1_rd", int'(mem_rd_o), (i <= 4) ? 1 : 0);
      if (i <= 4) chk("t1_addr", int'(mem_addr_o), 'h010 + i - 1);
      chk("t1_rvalid", int'(rvalid_o), (i >= 2 && i <= 5) ? 1 : 0);
      chk("t1_done", int'(done_o), (i == 5) ? 1 : 0);
      chk("t1_gnt", int'(gnt_o), (i <= 5) ? 1 : 0);
      if (i >= 2 && i <= 5) begin
        a = 10'h010 + 10'(i - 2);
        chk("t1_rdata", int'(rdata_o), int'(rom_f(a)));
      end
      if (i == 5) req_i[0] = 1'b0;
    end

    // 2: tie from reset, then alternation
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    req_i = 2'b11; base0_i = 10'h100; len0_i = 8'd2; base1_i = 10'h200; len1_i = 8'd2;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      chk("t2_gnt", int'(gnt_o),
          (i <= 3 || (i >= 9 && i <= 11)) ? 1 : ((i >= 5 && i <= 7) ? 2 : 0));
      chk("t2_sel", int'(sel_o), (i >= 5 && i <= 8) ? 1 : 0);
      chk("t2_done", int'(done_o), (i == 3 || i == 11) ? 1 : ((i == 7) ? 2 : 0));
      if (i == 3) req_i = 2'b10;
      if (i == 7) req_i = 2'b11;
      if (i == 11) req_i = 2'b00;
    end

    // 3: requester 0 re-requests at once while 1 is pending
    req_i = 2'b01; base0_i = 10'h020; len0_i = 8'd3; base1_i = 10'h040; len1_i = 8'd1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      chk("t3_gnt", int'(gnt_o), (i <= 4) ? 1 : ((i == 6 || i == 7) ? 2 : 0));
      chk("t3_sel", int'(sel_o), (i >= 6) ? 1 : 0);
      if (i == 6) begin
        chk("t3_rd", int'(mem_rd_o), 1);
        chk("t3_addr", int'(mem_addr_o), 'h040);
      end
      if (i == 7) chk("t3_done", int'(done_o), 2);
      if (i == 2) req_i = 2'b11;
      if (i == 7) req_i = 2'b00;
    end

    // 4: zero-length burst for requester 1
    req_i = 2'b10; len1_i = 8'd0;
    for (int i = 1; i <= 2; i++) begin
      @(negedge clk);
      chk("t4_rd", int'(mem_rd_o), 0);
      chk("t4_done", int'(done_o), (i == 1) ? 2 : 0);
      chk("t4_gnt", int'(gnt_o), (i == 1) ? 2 : 0);
      chk("t4_rvalid", int'(rvalid_o), 0);
      if (i == 1) req_i = 2'b00;
    end

    // 5: address wrap
    req_i = 2'b01; base0_i = 10'h3FE; len0_i = 8'd4;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 4) chk("t5_addr", int'(mem_addr_o), (i == 1) ? 'h3FE : ((i == 2) ? 'h3FF : i - 3));
      chk("t5_done", int'(done_o), (i == 5) ? 1 : 0);
      if (i == 5) req_i = 2'b00;
    end

    // 6: reset during read 2 of 4, then restart
    req_i = 2'b01; base0_i = 10'h155; len0_i = 8'd4;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      if (i == 3) begin
        chk("t6_rst_rd", int'(mem_rd_o), 0);
        chk("t6_rst_addr", int'(mem_addr_o), 0);
        chk("t6_rst_gnt", int'(gnt_o), 0);
        chk("t6_rst_rvalid", int'(rvalid_o), 0);
        chk("t6_rst_done", int'(done_o), 0);
        rst = 1'b0;
      end
      if (i >= 4 && i <= 7) chk("t6_addr", int'(mem_addr_o), 'h155 + i - 4);
      if (i >= 4) chk("t6_done", int'(done_o), (i == 8) ? 1 : 0);
      if (i == 2) rst = 1'b1;
      if (i == 8) req_i = 2'b00;
    end

    // Randomized traffic, including mid-burst reset and descriptor changes.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 249) == 0);
      for (int n = 0; n < 2; n++) begin
        if (req_i[n]) begin
          if (done_o[n] ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0))
            req_i[n] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          req_i[n] = 1'b1;
        end
      end
      if ($urandom_range(0, 1) == 1) begin
        base0_i = ADDR_W'($urandom);
        len0_i  = pick_len();
      end
      if ($urandom_range(0, 1) == 1) begin
        base1_i = ADDR_W'($urandom);
        len1_i  = pick_len();
      end
    end

    rst = 1'b0;
    req_i = 2'b00;
    repeat (50) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
